lcd_time_writer: RTL and testbench
==================================

Name: lcd_time_writer

Overview:
Upstream sequencer for lcd_disp_interface. Snapshots a BCD time value (HH:MM:SS) and drives the interface's data/send_data/ins_data handshake. Each frame issues one set-DDRAM-address instruction followed by 8 ASCII characters. It sits between the clock-keeping counters and the LCD interface, and consumes the interface's ready output.

Parameters:
ADDR, 8'h80, DDRAM address instruction sent at the start of every frame (line 1, column 0).
SEP_CHAR, 8'h3A, separator character, ASCII ':'.
ACK_TIMEOUT, 4, cycles to wait in WAIT_ACK for lcd_ready to fall before re-issuing the send (minimum 3).

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous, active-high.
time_bcd  in  24  {h_t, h_o, m_t, m_o, s_t, s_o}, 4-bit BCD digits, MSB first.
update  in  1  single-cycle request to redraw.
lcd_ready  in  1  ready output of lcd_disp_interface.
data  out  8  byte to the interface.
send_data  out  1  one-cycle send strobe.
ins_data  out  1  0 = instruction (RS=0), 1 = character data (RS=1).
busy  out  1  high while a frame is in progress.
frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- The interface accepts a send when idle and send_data=1. Its ready drops the cycle after acceptance, returns high when the transfer finishes, and is 0 throughout its init sequence.
- All outputs are registered.
- Reset state: data=0, send_data=0, ins_data=0, busy=0, frame_done=0, pending=0, idx=0, timeout counter=0, state=IDLE. Reset asserted mid-frame aborts the frame and wins over every other event in that cycle.
- pending flag: set by update in any state; cleared when a frame starts.
- Snapshot: time_bcd is latched only at frame start. Later changes do not affect the frame in flight.
- Frame content, idx 0..8:
  - idx 0: ADDR with ins_data=0.
  - idx 1..8: h_t, h_o, SEP_CHAR, m_t, m_o, SEP_CHAR, s_t, s_o with ins_data=1.
  - Digit d in 0..9 maps to 8'h30+d; digit > 9 maps to 8'h3F ('?').
- States:
  - IDLE: if (pending or update) and lcd_ready=1: latch snapshot, idx=0, clear pending, busy=1, go ISSUE. If lcd_ready=0, stay in IDLE with pending held.
  - ISSUE: data/ins_data set for idx; send_data=1 for exactly one cycle; timeout counter cleared; go WAIT_ACK.
  - WAIT_ACK: lcd_ready=0 -> WAIT_DONE. Otherwise increment the counter; when it reaches ACK_TIMEOUT -> ISSUE again with the same idx and data.
  - WAIT_DONE: wait for lcd_ready=1.
    - If idx=8: frame_done=1 for one cycle, busy=0, go IDLE.
    - Otherwise: idx+1, go ISSUE.
- data and ins_data are held stable from ISSUE through WAIT_DONE of each transfer.
- update arriving during busy sets pending. Multiple updates in one frame collapse to a single follow-up frame, which uses the time value at its own start.
- An update in the same cycle as frame_done: the next frame starts from IDLE on the following cycle, provided lcd_ready=1.
- send_data is never asserted while lcd_ready=0.
- Minimum frame cost: 9 transfers × (1 + 2 + interface transfer time) cycles.

Decomposition:
- Shared package lcd_pkg:
  - state enum {IDLE, ISSUE, WAIT_ACK, WAIT_DONE};
  - ASCII constants: zero 8'h30, colon 8'h3A, invalid 8'h3F;
  - LCD instruction constants: 8'h38 function set, 8'h0F display on, 8'h06 entry mode, 8'h80 set DDRAM base;
  - FRAME_LEN=9.
- Sub-module bcd_to_ascii: combinational, 4-bit digit -> 8-bit char, with invalid-digit handling. Instantiated once on the idx-selected digit.
- Bench responder model: accepts send only when its ready=1, drops ready 1 cycle later, raises it 20 cycles after acceptance.

Test Plan:
1. rst, then lcd_ready=0 for 100 cycles with an update pulse at cycle 10 -> send_data stays 0, busy stays 0. Raise lcd_ready -> frame starts within 2 cycles.
2. time_bcd=24'h235958, update, responder model -> bytes 0x80 (ins 0), then 0x32,0x33,0x3A,0x35,0x39,0x3A,0x35,0x38 (ins 1). Exactly 9 send_data pulses; frame_done pulses once after the 9th ready rise.
3. Frame running with 12:34:56; change time to 00:00:00 and pulse update twice mid-frame -> current frame completes with 0x31,0x32,..., then exactly one more frame of 0x30,0x30,0x3A,0x30,0x30,0x3A,0x30,0x30.
4. time_bcd=24'h12345A -> last character 0x3F, all others correct.
5. Responder ignores the first send (ready stays 1) -> send_data re-pulses after ACK_TIMEOUT=4 cycles with identical data 0x80/ins 0; frame then completes normally.
6. rst asserted during idx=4 -> next cycle all outputs 0 and busy=0. No send_data until a new update, which restarts at idx 0 with 0x80.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types and constants for the LCD time writer.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam logic [7:0] c_ascii_zero    = 8'h30;
    localparam logic [7:0] c_ascii_colon   = 8'h3A;
    localparam logic [7:0] c_ascii_invalid = 8'h3F;

    localparam logic [7:0] c_ins_function_set = 8'h38;
    localparam logic [7:0] c_ins_display_on   = 8'h0F;
    localparam logic [7:0] c_ins_entry_mode   = 8'h06;
    localparam logic [7:0] c_ins_set_ddram    = 8'h80;

    // One address instruction plus eight characters
    localparam int c_frame_len = 9;

endpackage
`default_nettype wire

// File: rtl/lcd_time_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_time_writer_if
// Brief    : Time input and LCD-interface handshake bundle for the writer.
// Revision : 1.0
// ============================================================================
interface lcd_time_writer_if;

    logic [23:0] time_bcd;
    logic        update;
    logic        lcd_ready;
    logic [7:0]  data;
    logic        send_data;
    logic        ins_data;
    logic        busy;
    logic        frame_done;

    modport master (
        input  time_bcd,
        input  update,
        input  lcd_ready,
        output data,
        output send_data,
        output ins_data,
        output busy,
        output frame_done
    );

    modport slave (
        output time_bcd,
        output update,
        output lcd_ready,
        input  data,
        input  send_data,
        input  ins_data,
        input  busy,
        input  frame_done
    );

endinterface
`default_nettype wire

// File: rtl/bcd_to_ascii.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_ascii
// Brief    : Converts one BCD digit to its ASCII character ('?' if invalid).
// Revision : 1.0
// ============================================================================
module bcd_to_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [7:0] o_ascii
);

    always_comb begin
        if (i_digit <= 4'd9) begin
            o_ascii = c_ascii_zero + {4'h0, i_digit};
        end else begin
            o_ascii = c_ascii_invalid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_time_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_time_writer
// Brief    : Sequences a snapshotted HH:MM:SS value into the LCD interface
//            as one DDRAM-address instruction followed by 8 characters.
// Revision : 1.0
// ============================================================================
module lcd_time_writer
    import lcd_pkg::*;
#(
    parameter logic [7:0] ADDR        = c_ins_set_ddram,
    parameter logic [7:0] SEP_CHAR    = c_ascii_colon,
    parameter int         ACK_TIMEOUT = 4
)(
    input  logic               clk,
    input  logic               rst,
    lcd_time_writer_if.master  bus
);

    localparam int                 c_cnt_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);
    localparam logic [3:0]         c_last_idx = 4'(c_frame_len - 1);

    localparam logic [1:0] c_st_idle      = IDLE;
    localparam logic [1:0] c_st_issue     = ISSUE;
    localparam logic [1:0] c_st_wait_ack  = WAIT_ACK;
    localparam logic [1:0] c_st_wait_done = WAIT_DONE;

    logic [1:0]         r_state;
    logic [3:0]         r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pending;
    logic [23:0]        r_snap;
    logic [7:0]         r_data;
    logic               r_send;
    logic               r_ins;
    logic               r_busy;
    logic               r_done;

    logic [3:0]         w_next_idx;
    logic [3:0]         w_digit;
    logic               w_is_sep;
    logic [7:0]         w_digit_char;
    logic [7:0]         w_char;

    assign w_next_idx = r_idx + 4'd1;

    // Character for the transfer that follows the current one
    always_comb begin
        w_digit  = 4'h0;
        w_is_sep = 1'b0;
        case (w_next_idx)
            4'd1:    w_digit  = r_snap[23:20];
            4'd2:    w_digit  = r_snap[19:16];
            4'd3:    w_is_sep = 1'b1;
            4'd4:    w_digit  = r_snap[15:12];
            4'd5:    w_digit  = r_snap[11:8];
            4'd6:    w_is_sep = 1'b1;
            4'd7:    w_digit  = r_snap[7:4];
            4'd8:    w_digit  = r_snap[3:0];
            default: w_digit  = 4'h0;
        endcase
    end

    bcd_to_ascii u_bcd_to_ascii (
        .i_digit (w_digit),
        .o_ascii (w_digit_char)
    );

    assign w_char = w_is_sep ? SEP_CHAR : w_digit_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_idx     <= 4'd0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_snap    <= 24'h0;
            r_data    <= 8'h00;
            r_send    <= 1'b0;
            r_ins     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_send <= 1'b0;
            r_done <= 1'b0;
            if (bus.update) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    // Frame start consumes any pending request, including one arriving now
                    if ((r_pending || bus.update) && bus.lcd_ready) begin
                        r_snap    <= bus.time_bcd;
                        r_idx     <= 4'd0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_data    <= ADDR;
                        r_ins     <= 1'b0;
                        r_send    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= c_st_issue;
                    end
                end

                c_st_issue: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait_ack;
                end

                c_st_wait_ack: begin
                    if (!bus.lcd_ready) begin
                        r_state <= c_st_wait_done;
                    end else if (r_cnt == c_cnt_last) begin
                        // Send was not taken; repeat it with data/ins_data untouched
                        r_send  <= 1'b1;
                        r_state <= c_st_issue;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                c_st_wait_done: begin
                    if (bus.lcd_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_data  <= w_char;
                            r_ins   <= 1'b1;
                            r_send  <= 1'b1;
                            r_state <= c_st_issue;
                        end
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.data       = r_data;
    assign bus.send_data  = r_send;
    assign bus.ins_data   = r_ins;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_time_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_time_writer
// Brief    : Scoreboard bench for lcd_time_writer with an LCD responder model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_time_writer;

    localparam int ACK_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_time_writer_if bus();

    lcd_time_writer #(
        .ADDR        (8'h80),
        .SEP_CHAR    (8'h3A),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_sends  = 0;
    int n_pulses = 0;
    int n_frames = 0;
    int n_ignored = 0;
    int frame_sends = 0;
    int cyc = 0;
    int last_ign = -1;
    bit busy_seen = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_item;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: accepts when ready, ready low from the next cycle for 20 cycles
    bit force_low   = 1'b1;
    bit ignore_next = 1'b0;
    int rcnt = 0;
    always @(posedge clk) begin
        if (force_low) begin
            bus.lcd_ready <= 1'b0;
            rcnt          <= 0;
        end else if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) bus.lcd_ready <= 1'b1;
        end else if (bus.lcd_ready && bus.send_data) begin
            if (ignore_next) begin
                ignore_next <= 1'b0;
            end else begin
                bus.lcd_ready <= 1'b0;
                rcnt          <= 20;
            end
        end else begin
            bus.lcd_ready <= 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            frame_sends = 0;
        end else begin
            if (bus.busy) busy_seen = 1'b1;
            if (bus.send_data) begin
                n_pulses++;
                chk("send_while_not_ready", {31'd0, bus.lcd_ready}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_send: got 0x%0h, expected no send", {bus.ins_data, bus.data});
                end else if (ignore_next) begin
                    chk("ignored_send", {23'd0, bus.ins_data, bus.data}, {23'd0, exp_q[0]});
                    last_ign = cyc;
                    n_ignored++;
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("byte", {23'd0, bus.ins_data, bus.data}, {23'd0, exp_item});
                    if (last_ign >= 0) begin
                        chk("retry_gap", cyc - last_ign, ACK_TIMEOUT + 1);
                        last_ign = -1;
                    end
                    n_sends++;
                    frame_sends++;
                end
            end
            if (bus.frame_done) begin
                n_frames++;
                chk("sends_per_frame", frame_sends, 9);
                frame_sends = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_update();
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
    endtask

    task automatic push_frame(input logic [63:0] chars);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 7; i >= 0; i--) exp_q.push_back({1'b1, chars[i*8 +: 8]});
    endtask

    task automatic wait_frames(input int target, input string name);
        int budget;
        budget = 3000;
        while (n_frames < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(name, n_frames, target);
    endtask

    task automatic wait_sends(input int target, input string name);
        int budget;
        budget = 1000;
        while (n_sends < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(name, n_sends, target);
    endtask

    initial begin
        int k;
        int base;
        rst          = 1'b1;
        bus.update   = 1'b0;
        bus.time_bcd = 24'h0;
        tick(3);
        chk("rst_data",       {24'd0, bus.data}, 32'd0);
        chk("rst_send",       {31'd0, bus.send_data}, 32'd0);
        chk("rst_ins",        {31'd0, bus.ins_data}, 32'd0);
        chk("rst_busy",       {31'd0, bus.busy}, 32'd0);
        chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        rst = 1'b0;

        // 1: request held while the interface is still initialising
        busy_seen    = 1'b0;
        bus.time_bcd = 24'h000102;
        tick(10);
        pulse_update();
        tick(89);
        chk("t1_no_send", n_pulses, 0);
        chk("t1_no_busy", {31'd0, busy_seen}, 32'd0);
        push_frame(64'h30303A30313A3032);
        force_low = 1'b0;
        k = 0;
        while (!bus.busy && k < 2) begin
            @(negedge clk);
            k++;
        end
        chk("t1_start_latency", {31'd0, bus.busy}, 32'd1);
        wait_frames(1, "t1_frame_done");

        // 2: 23:59:58
        bus.time_bcd = 24'h235958;
        push_frame(64'h32333A35393A3538);
        pulse_update();
        wait_frames(2, "t2_frame_done");
        tick(30);
        chk("t2_single_done", n_frames, 2);
        chk("t2_pulses", n_pulses, 18);

        // 3: two updates mid-frame collapse into one follow-up frame
        bus.time_bcd = 24'h123456;
        push_frame(64'h31323A33343A3536);
        pulse_update();
        wait_sends(21, "t3_mid_frame");
        bus.time_bcd = 24'h000000;
        push_frame(64'h30303A30303A3030);
        pulse_update();
        tick(5);
        pulse_update();
        wait_frames(4, "t3_frames_done");
        tick(300);
        chk("t3_frame_count", n_frames, 4);
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_idle_busy", {31'd0, bus.busy}, 32'd0);

        // 4: invalid seconds-ones digit
        bus.time_bcd = 24'h12345A;
        push_frame(64'h31323A33343A353F);
        pulse_update();
        wait_frames(5, "t4_frame_done");

        // 5: first send ignored, re-issued after the timeout
        ignore_next  = 1'b1;
        bus.time_bcd = 24'h010203;
        push_frame(64'h30313A30323A3033);
        pulse_update();
        wait_frames(6, "t5_frame_done");
        chk("t5_ignored", n_ignored, 1);

        // 6: reset in the middle of a frame
        bus.time_bcd = 24'h235958;
        push_frame(64'h32333A35393A3538);
        pulse_update();
        wait_sends(n_sends + 5, "t6_reach_idx4");
        rst = 1'b1;
        @(negedge clk);
        chk("t6_data",       {24'd0, bus.data}, 32'd0);
        chk("t6_send",       {31'd0, bus.send_data}, 32'd0);
        chk("t6_ins",        {31'd0, bus.ins_data}, 32'd0);
        chk("t6_busy",       {31'd0, bus.busy}, 32'd0);
        chk("t6_frame_done", {31'd0, bus.frame_done}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        base = n_pulses;
        tick(60);
        chk("t6_no_send", n_pulses, base);
        chk("t6_no_done", n_frames, 6);
        push_frame(64'h32333A35393A3538);
        pulse_update();
        wait_frames(7, "t6_restart_done");
        tick(10);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
